// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between fetch and data ports
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              pc_stall
);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(MAX_STREAK + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   streak;
    logic            owner_dm, owner_we, dm_win, done;

    // IF overrides DM priority only once DM has starved it for MAX_STREAK grants
    assign dm_win    = dm_req & ~(if_req & (streak == SW'(MAX_STREAK)));
    assign mem_en    = if_gnt | dm_gnt;
    assign mem_we    = dm_gnt & dm_we;
    assign mem_addr  = dm_win ? dm_addr : if_addr;
    assign mem_wdata = dm_wdata;
    assign busy      = state == WAIT;
    assign pc_stall  = if_req & ~if_rvalid;

    // grant in IDLE (suppressed during reset), finish WAIT when the read data is on mem_rdata
    always_comb begin
        state_nx = state;
        if_gnt   = 1'b0;
        dm_gnt   = 1'b0;
        done     = 1'b0;
        if (state == IDLE) begin
            dm_gnt = rst & dm_win;
            if_gnt = rst & if_req & ~dm_win;
            state_nx = (dm_gnt | if_gnt) ? WAIT : IDLE;
        end else if (cnt == CW'(1)) begin
            done     = 1'b1;
            state_nx = IDLE;
        end
    end

    // state, latency counter, ownership, result registers and starvation streak
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            streak    <= '0;
            owner_dm  <= 1'b0;
            owner_we  <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state <= state_nx;
            if (mem_en) begin
                cnt      <= CW'(MEM_LAT);
                owner_dm <= dm_gnt;
                owner_we <= dm_gnt & dm_we;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
            if_rvalid <= done & ~owner_dm;
            dm_rvalid <= done & owner_dm;
            if (done & ~owner_dm) if_rdata <= mem_rdata;
            if (done & owner_dm & ~owner_we) dm_rdata <= mem_rdata;
            streak <= (~if_req | if_gnt) ? '0 :
                      (dm_gnt && streak != SW'(MAX_STREAK)) ? streak + 1'b1 : streak;
        end
    end
endmodule
